// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the ID-stage hazard control unit: FSM state
// encodings, operand forward-select codes and the hard-wired zero register.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_BRFLUSH = 2'd2
    } hcu_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_EXE = 2'b01;  // EXE-stage ALU result
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_LD  = 2'b11;  // MEM-stage load data

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a source register names a real (non-zero) destination.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dest);
        return (src == dest) && (dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forward select. EXE ALU results take precedence over anything
// in MEM; a load still in EXE is not forwardable and falls through to MEM.
module fwd_sel
    import hazard_ctrl_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ex_destR,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mem_destR,
    output logic [1:0] sel
);

    // Pick the youngest producer of src; no forward when the operand is unused.
    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (ewreg && !em2reg && reg_hit(src, ex_destR)) begin
                sel = FWD_EXE;
            end else if (mwreg && reg_hit(src, mem_destR)) begin
                sel = mm2reg ? FWD_LD : FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the ID/EXE boundary: load-use stall, taken-branch flush,
// operand forwarding selects and saturating hazard statistics counters.
//
// Control outputs are combinational from the state register and the current
// inputs; a high rst forces all of them (and both forward selects) to zero in
// the same cycle, so a reset abandons any stall or flush immediately.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ex_destR,
    input  logic             e_branch_taken,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mem_destR,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idexe,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       FLUSH_INIT = FLUSH_CYCLES[1:0];
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    hcu_state_t state, state_nxt;
    logic [1:0] flush_left, flush_left_nxt;
    logic       load_use;
    logic       stall;
    logic [1:0] sel_a, sel_b;

    // A load in EXE whose destination is read by the ID instruction.
    always_comb begin
        load_use = ewreg && em2reg &&
                   ((id_use_rs && reg_hit(id_rs, ex_destR)) ||
                    (id_use_rt && reg_hit(id_rt, ex_destR)));
    end

    fwd_sel u_fwd_rs (
        .src       (id_rs),
        .use_src   (id_use_rs),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ex_destR  (ex_destR),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mem_destR (mem_destR),
        .sel       (sel_a)
    );

    fwd_sel u_fwd_rt (
        .src       (id_rt),
        .use_src   (id_use_rt),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ex_destR  (ex_destR),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mem_destR (mem_destR),
        .sel       (sel_b)
    );

    // Next state and control outputs; a taken branch outranks a load-use
    // hazard because the ID instruction is discarded by the flush anyway.
    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        stall          = 1'b0;
        flush_ifid     = 1'b0;
        bubble_idexe   = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (e_branch_taken) begin
                        flush_ifid   = 1'b1;
                        bubble_idexe = 1'b1;
                        if (FLUSH_CYCLES > 0) begin
                            state_nxt      = ST_BRFLUSH;
                            flush_left_nxt = FLUSH_INIT;
                        end
                    end else if (load_use) begin
                        stall        = 1'b1;
                        bubble_idexe = 1'b1;
                        state_nxt    = ST_LDSTALL;
                    end
                end
                ST_LDSTALL: begin
                    // The load is now in MEM; forwarding resolves the hazard.
                    state_nxt = ST_RUN;
                end
                ST_BRFLUSH: begin
                    // Any branch seen here is in a bubbled slot and is ignored.
                    flush_ifid   = 1'b1;
                    bubble_idexe = 1'b1;
                    if (flush_left <= 2'd1) begin
                        flush_left_nxt = 2'd0;
                        state_nxt      = ST_RUN;
                    end else begin
                        flush_left_nxt = flush_left - 2'd1;
                    end
                end
                default: begin
                    state_nxt      = ST_RUN;
                    flush_left_nxt = 2'd0;
                end
            endcase
        end
    end

    // Output drive for the stall pair and the reset-gated forward selects.
    always_comb begin
        stall_pc   = stall;
        stall_ifid = stall;
        fwda       = rst ? FWD_RF : sel_a;
        fwdb       = rst ? FWD_RF : sel_b;
    end

    // FSM state and flush down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            flush_left <= 2'd0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    // Saturating hazard statistics; they hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_ifid && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit (FLUSH_CYCLES=1, CNT_W=4). Every cycle the
// expected output word is produced by a reference model, queued, and popped
// for comparison against the DUT; directed checks cover the named scenarios.
module tb_hazard_ctrl_unit;

    localparam int FC    = 1;
    localparam int CNT_W = 4;
    localparam int W     = 16;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt;
    logic             id_use_rs, id_use_rt;
    logic             ewreg, em2reg;
    logic [4:0]       ex_destR;
    logic             e_branch_taken;
    logic             mwreg, mm2reg;
    logic [4:0]       mem_destR;
    logic             stall_pc, stall_ifid, flush_ifid, bubble_idexe;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    int n_vec;
    int n_err;

    // Reference model state: 0 run, 1 load stall, 2 branch flush.
    int m_mode;
    int m_left;
    int m_scnt;
    int m_fcnt;

    hazard_ctrl_unit #(
        .FLUSH_CYCLES (FC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .ewreg          (ewreg),
        .em2reg         (em2reg),
        .ex_destR       (ex_destR),
        .e_branch_taken (e_branch_taken),
        .mwreg          (mwreg),
        .mm2reg         (mm2reg),
        .mem_destR      (mem_destR),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .flush_ifid     (flush_ifid),
        .bubble_idexe   (bubble_idexe),
        .fwda           (fwda),
        .fwdb           (fwdb),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] src, input logic use_src);
        if (!use_src || src == 5'd0) return 2'b00;
        if (ewreg && !em2reg && src == ex_destR) return 2'b01;
        if (mwreg && src == mem_destR) return mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic sp, fl, bb, lu;
        logic [1:0] fa, fb;
        logic [3:0] sc, fc4;
        sp = 1'b0; fl = 1'b0; bb = 1'b0; fa = 2'b00; fb = 2'b00;
        lu = ewreg && em2reg && (ex_destR != 5'd0) &&
             ((id_use_rs && id_rs == ex_destR) || (id_use_rt && id_rt == ex_destR));
        if (!rst) begin
            if (m_mode == 0) begin
                if (e_branch_taken) begin fl = 1'b1; bb = 1'b1; end
                else if (lu) begin sp = 1'b1; bb = 1'b1; end
            end else if (m_mode == 2) begin
                fl = 1'b1; bb = 1'b1;
            end
            fa = fwd_model(id_rs, id_use_rs);
            fb = fwd_model(id_rt, id_use_rt);
        end
        sc  = 4'(m_scnt);
        fc4 = 4'(m_fcnt);
        return {sp, sp, fl, bb, fa, fb, sc, fc4};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_left = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (last_exp[15] && m_scnt < 15) m_scnt++;
            if (last_exp[13] && m_fcnt < 15) m_fcnt++;
            case (m_mode)
                0: begin
                    if (e_branch_taken) begin
                        if (FC > 0) begin m_mode = 2; m_left = FC; end
                    end else if (last_exp[15]) begin
                        m_mode = 1;
                    end
                end
                1: m_mode = 0;
                default: begin
                    m_left--;
                    if (m_left <= 0) begin m_left = 0; m_mode = 0; end
                end
            endcase
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; ex_destR = 5'd0; e_branch_taken = 1'b0;
        mwreg = 1'b0; mm2reg = 1'b0; mem_destR = 5'd0;
    endtask

    task automatic set_load_use();
        set_idle();
        ewreg = 1'b1; em2reg = 1'b1; ex_destR = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    // Scoreboard: expected word queued once inputs settle, then popped against the DUT.
    task automatic apply(input string tag);
        logic [W-1:0] e, o;
        #1;
        e = model_out();
        exp_q.push_back(e);
        last_exp = e;
        o = {stall_pc, stall_ifid, flush_ifid, bubble_idexe, fwda, fwdb, stall_cnt, flush_cnt};
        check(tag, o, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_mode = 0; m_left = 0; m_scnt = 0; m_fcnt = 0;
        last_exp = '0;
        rst = 1'b1;
        set_idle();
        @(negedge clk);

        // Reset with an active load-use pattern: everything quiet.
        set_load_use();
        apply("reset0");
        tick();
        apply("reset1");
        check("rst_stall_pc", W'(stall_pc), W'(0));
        check("rst_bubble", W'(bubble_idexe), W'(0));
        check("rst_fwda", W'(fwda), W'(0));
        check("rst_cnts", W'({stall_cnt, flush_cnt}), W'(0));
        tick();

        // Load-use: stall one cycle, then forward load data from MEM.
        rst = 1'b0;
        set_load_use();
        apply("lu_c0");
        check("lu_stall_pc", W'({stall_pc, stall_ifid, bubble_idexe}), W'(3'b111));
        tick();
        set_idle();
        id_rs = 5'd8; id_use_rs = 1'b1;
        mwreg = 1'b1; mm2reg = 1'b1; mem_destR = 5'd8;
        apply("lu_c1");
        check("lu_c1_stall", W'(stall_pc), W'(0));
        check("lu_c1_fwda", W'(fwda), W'(2'b11));
        check("lu_c1_scnt", W'(stall_cnt), W'(1));
        tick();

        // ALU forward: EXE wins over MEM for rt.
        set_idle();
        ewreg = 1'b1; ex_destR = 5'd5; mwreg = 1'b1; mem_destR = 5'd5;
        id_rt = 5'd5; id_use_rt = 1'b1;
        apply("alu_fwd");
        check("alu_fwdb", W'(fwdb), W'(2'b01));
        check("alu_nostall", W'(stall_pc), W'(0));
        tick();

        // Taken branch with a simultaneous load-use: two flush cycles, no stall.
        set_load_use();
        e_branch_taken = 1'b1;
        apply("br_c0");
        check("br_c0_flush", W'({flush_ifid, bubble_idexe, stall_pc}), W'(3'b110));
        tick();
        apply("br_c1");
        check("br_c1_flush", W'(flush_ifid), W'(1));
        tick();
        set_idle();
        apply("br_c2");
        check("br_c2_run", W'(flush_ifid), W'(0));
        check("br_fcnt", W'(flush_cnt), W'(2));
        tick();

        // Register zero is neither a hazard nor a forward source.
        set_idle();
        ewreg = 1'b1; em2reg = 1'b1; ex_destR = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        apply("zero");
        check("zero_stall", W'(stall_pc), W'(0));
        check("zero_fwda", W'(fwda), W'(0));
        tick();

        // Saturation: 20 load-use/stall pairs push stall_cnt to its ceiling.
        for (int i = 0; i < 20; i++) begin
            set_load_use();
            apply("sat_lu");
            tick();
            apply("sat_ld");
            tick();
        end
        set_idle();
        apply("sat_end");
        check("sat_scnt", W'(stall_cnt), W'(15));
        tick();

        // Reset in the middle of a branch flush abandons it.
        set_idle();
        e_branch_taken = 1'b1;
        apply("rbr_c0");
        tick();
        e_branch_taken = 1'b0;
        rst = 1'b1;
        apply("rbr_rst");
        check("rbr_rst_flush", W'(flush_ifid), W'(0));
        tick();
        rst = 1'b0;
        apply("rbr_after");
        check("rbr_after_flush", W'(flush_ifid), W'(0));
        check("rbr_after_fcnt", W'(flush_cnt), W'(0));
        tick();

        // Random traffic over a small register set to force collisions.
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 39) == 0);
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_use_rs      = 1'($urandom_range(0, 1));
            id_use_rt      = 1'($urandom_range(0, 1));
            ewreg          = 1'($urandom_range(0, 1));
            em2reg         = 1'($urandom_range(0, 1));
            ex_destR       = 5'($urandom_range(0, 3));
            e_branch_taken = ($urandom_range(0, 7) == 0);
            mwreg          = 1'($urandom_range(0, 1));
            mm2reg         = 1'($urandom_range(0, 1));
            mem_destR      = 5'($urandom_range(0, 3));
            apply("rand");
            tick();
        end

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
